// File: rtl/karat_recombine_pipe.sv
// Karatsuba recombination: two-stage elastic pipeline, z2<<2SW + mid<<SW + z0.
// Optional borrow flag on mid via KARAT_MID_CHECK_EN (adds Mid_Err_o).
module karat_recombine_pipe #(
  parameter int SW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*SW-1:0]   Z0_i,
  input  logic [2*SW-1:0]   Z2_i,
  input  logic [2*SW+1:0]   Z1_i,
  input  logic              Valid_i,
  output logic              Ready_o,
  output logic [4*SW-1:0]   Data_S_o,
  output logic              Valid_o,
  input  logic              Ready_i
`ifdef KARAT_MID_CHECK_EN
  ,
  output logic              Mid_Err_o
`endif
);

  localparam int MW = 2*SW+2;
  localparam int DW = 4*SW;

  logic              s1_v_q;
  logic [MW-1:0]     mid_q;
  logic [MW-1:0]     mid_d;
  logic [2*SW-1:0]   z0_q;
  logic [2*SW-1:0]   z2_q;
  logic              s2_v_q;
  logic [DW-1:0]     data_q;
  logic [DW-1:0]     data_d;
  logic              en1;
  logic              en2;

  assign en2     = !s2_v_q | Ready_i;
  assign en1     = !s1_v_q | en2;
  assign Ready_o = en1;

  always_comb begin
    mid_d = Z1_i - MW'(Z0_i) - MW'(Z2_i);
  end

  // mid is at most 3SW+2 bits after the shift, so zero-extend before it
  always_comb begin
    data_d = {z2_q, z0_q} + (DW'(mid_q) << SW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      mid_q  <= '0;
      z0_q   <= '0;
      z2_q   <= '0;
    end else if (en1) begin
      s1_v_q <= Valid_i;
      if (Valid_i) begin
        mid_q <= mid_d;
        z0_q  <= Z0_i;
        z2_q  <= Z2_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      data_q <= '0;
    end else if (en2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        data_q <= data_d;
      end
    end
  end

  assign Data_S_o = data_q;
  assign Valid_o  = s2_v_q;

`ifdef KARAT_MID_CHECK_EN
  logic err1_d;
  logic err1_q;
  logic err2_q;

  // one extra bit keeps the borrow of z1 - (z0 + z2)
  always_comb begin
    err1_d = {1'b0, Z1_i} < ({3'b000, Z0_i} + {3'b000, Z2_i});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      if (en1 && Valid_i) err1_q <= err1_d;
      if (en2 && s1_v_q)  err2_q <= err1_q;
    end
  end

  assign Mid_Err_o = err2_q;
`endif

endmodule

// File: tb/tb_karat_recombine_pipe.sv
// Randomized self-checking bench for karat_recombine_pipe at SW=4.
// Scoreboard model: plain modular arithmetic on a FIFO of accepted triples.
module tb_karat_recombine_pipe;

  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  Z0_i = '0;
  logic [7:0]  Z2_i = '0;
  logic [9:0]  Z1_i = '0;
  logic        Valid_i = 1'b0;
  logic        Ready_o;
  logic [15:0] Data_S_o;
  logic        Valid_o;
  logic        Ready_i = 1'b1;
`ifdef KARAT_MID_CHECK_EN
  logic        Mid_Err_o;
`endif

  karat_recombine_pipe #(.SW(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Z0_i     (Z0_i),
    .Z2_i     (Z2_i),
    .Z1_i     (Z1_i),
    .Valid_i  (Valid_i),
    .Ready_o  (Ready_o),
    .Data_S_o (Data_S_o),
    .Valid_o  (Valid_o),
    .Ready_i  (Ready_i)
`ifdef KARAT_MID_CHECK_EN
    ,
    .Mid_Err_o(Mid_Err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   nout   = 0;
  logic acc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int z0, input int z2, input int z1);
    exp_t r;
    int   mid;
    mid = (z1 - z0 - z2) & 32'h3FF;
    r.p = 16'(((z2 << 8) + ((mid << 4) & 32'hFFFF) + z0) & 32'hFFFF);
    r.e = (z1 < z0 + z2);
    return r;
  endfunction

  task automatic drive(input int z0, input int z2, input int z1,
                       input logic v);
    Z0_i    = 8'(z0);
    Z2_i    = 8'(z2);
    Z1_i    = 10'(z1);
    Valid_i = v;
  endtask

  task automatic rand_legal();
    logic [7:0] a;
    logic [7:0] b;
    int         s;
    int         t;
    a = 8'($urandom);
    b = 8'($urandom);
    s = int'(a[3:0]) + int'(a[7:4]);
    t = int'(b[3:0]) + int'(b[7:4]);
    drive(int'(a[3:0]) * int'(b[3:0]), int'(a[7:4]) * int'(b[7:4]),
          s * t, 1'b1);
  endtask

  task automatic step(output logic a_o);
    exp_t e;
    @(negedge clk);
    if (Valid_o && Ready_i) begin
      nout++;
      if (q.size() == 0) begin
        chk("spurious_out", 32'(Valid_o), 32'd0);
      end else begin
        e = q.pop_front();
        chk("data", 32'(Data_S_o), 32'(e.p));
`ifdef KARAT_MID_CHECK_EN
        chk("mid_err", 32'(Mid_Err_o), 32'(e.e));
`endif
      end
    end
    a_o = Valid_i && Ready_o;
    if (a_o) q.push_back(model(int'(Z0_i), int'(Z2_i), int'(Z1_i)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int acc_cnt;
    int bud;

    #12;
    chk("rst_valid", 32'(Valid_o), 32'd0);
    chk("rst_data", 32'(Data_S_o), 32'd0);
    chk("rst_ready", 32'(Ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(Ready_o), 32'd1);

    // single transfer, latency 2
    drive(143, 120, 525, 1'b1);
    step(acc);
    chk("single_acc", 32'(acc), 32'd1);
    drive(0, 0, 0, 1'b0);
    chk("lat1_valid", 32'(Valid_o), 32'd0);
    step(acc);
    chk("lat2_valid", 32'(Valid_o), 32'd1);
    chk("single_data", 32'(Data_S_o), 32'h88EF);
`ifdef KARAT_MID_CHECK_EN
    chk("single_err", 32'(Mid_Err_o), 32'd0);
`endif
    step(acc);

    // max operands then zeros
    drive(225, 225, 900, 1'b1);
    step(acc);
    drive(0, 0, 0, 1'b1);
    step(acc);
    drive(0, 0, 0, 1'b0);
    chk("max_data", 32'(Data_S_o), 32'hFE01);
    step(acc);
    chk("zero_data", 32'(Data_S_o), 32'h0000);
    chk("zero_valid", 32'(Valid_o), 32'd1);
    step(acc);

    // streaming: 8 back-to-back
    n0 = nout;
    for (int i = 0; i < 8; i++) begin
      rand_legal();
      step(acc);
      chk("stream_ready", 32'(acc), 32'd1);
    end
    drive(0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) step(acc);
    chk("stream_count", 32'(nout - n0), 32'd8);
    step(acc);
    chk("stream_empty", 32'(Valid_o), 32'd0);

    // backpressure: 3 offered, 4 stalled cycles
    Ready_i = 1'b0;
    acc_cnt = 0;
    rand_legal();
    for (int c = 0; c < 4; c++) begin
      if (c >= 2) begin
        @(negedge clk);
        chk("bp_ready_low", 32'(Ready_o), 32'd0);
        chk("bp_valid", 32'(Valid_o), 32'd1);
        if (q.size() > 0) chk("bp_hold", 32'(Data_S_o), 32'(q[0].p));
      end
      step(acc);
      if (acc) begin
        acc_cnt++;
        if (acc_cnt < 3) rand_legal();
        else drive(0, 0, 0, 1'b0);
      end
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd2);
    Ready_i = 1'b1;
    n0 = nout;
    bud = 0;
    while ((q.size() > 0 || Valid_i) && bud < 20) begin
      step(acc);
      if (acc) drive(0, 0, 0, 1'b0);
      bud++;
    end
    chk("bp_timeout", 32'(bud < 20), 32'd1);
    chk("bp_out_count", 32'(nout - n0), 32'd3);

    // random mix with random backpressure
    for (int i = 0; i < 60; i++) begin
      Ready_i = 1'($urandom_range(0, 3) != 0);
      if (!Valid_i && $urandom_range(0, 3) != 0) rand_legal();
      step(acc);
      if (acc) drive(0, 0, 0, 1'b0);
    end
    Ready_i = 1'b1;
    drive(0, 0, 0, 1'b0);
    bud = 0;
    while (q.size() > 0 && bud < 20) begin
      step(acc);
      bud++;
    end
    chk("mix_drain", 32'(q.size()), 32'd0);

    // async reset with both stages full
    Ready_i = 1'b0;
    rand_legal();
    step(acc);
    rand_legal();
    step(acc);
    drive(0, 0, 0, 1'b0);
    chk("full_valid", 32'(Valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(Valid_o), 32'd0);
    chk("arst_data", 32'(Data_S_o), 32'd0);
    chk("arst_ready", 32'(Ready_o), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    Ready_i = 1'b1;
    @(posedge clk);
    #1;
    n0 = nout;
    for (int i = 0; i < 3; i++) step(acc);
    chk("no_stale", 32'(nout - n0), 32'd0);
    drive(143, 120, 525, 1'b1);
    step(acc);
    drive(0, 0, 0, 1'b0);
    step(acc);
    chk("rst_next_valid", 32'(Valid_o), 32'd1);
    chk("rst_next_data", 32'(Data_S_o), 32'h88EF);
    step(acc);

`ifdef KARAT_MID_CHECK_EN
    drive(10, 10, 5, 1'b1);
    step(acc);
    drive(143, 120, 525, 1'b1);
    step(acc);
    drive(0, 0, 0, 1'b0);
    chk("err_flag", 32'(Mid_Err_o), 32'd1);
    chk("err_valid", 32'(Valid_o), 32'd1);
    step(acc);
    chk("err_clear", 32'(Mid_Err_o), 32'd0);
    step(acc);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
